// File: rtl/segment_scan_driver_if.sv
// Capture/display bundle between the calculator result path and the scan driver.
// The master drives the value to show; the slave (the driver) returns busy and the display pins.
interface segment_scan_driver_if #(
    parameter int NUM_DIGITS  = 4,
    parameter int VALUE_WIDTH = 8
) ();
    logic                   load;
    logic [VALUE_WIDTH-1:0] value;
    logic                   is_negative;
    logic                   is_dec;
    logic                   blank_zeros;
    logic                   busy;
    logic [NUM_DIGITS-1:0]  digit_en;
    logic [6:0]             segments;

    modport master (
        output load, value, is_negative, is_dec, blank_zeros,
        input  busy, digit_en, segments
    );

    modport slave (
        input  load, value, is_negative, is_dec, blank_zeros,
        output busy, digit_en, segments
    );
endinterface

// File: rtl/segment_scan_driver.sv
// Multiplexed seven-segment driver: captures a value, converts to BCD if needed, and
// scans the committed frame onto a shared active-low segment bus with sign and blanking.

module hex_display (
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);
    always_comb begin
        seg_o = 7'h7F;
        case (nibble_i)
            4'h0: seg_o = 7'h40;
            4'h1: seg_o = 7'h79;
            4'h2: seg_o = 7'h24;
            4'h3: seg_o = 7'h30;
            4'h4: seg_o = 7'h19;
            4'h5: seg_o = 7'h12;
            4'h6: seg_o = 7'h02;
            4'h7: seg_o = 7'h78;
            4'h8: seg_o = 7'h00;
            4'h9: seg_o = 7'h10;
            4'hA: seg_o = 7'h08;
            4'hB: seg_o = 7'h03;
            4'hC: seg_o = 7'h46;
            4'hD: seg_o = 7'h21;
            4'hE: seg_o = 7'h06;
            4'hF: seg_o = 7'h0E;
            default: seg_o = 7'h7F;
        endcase
    end
endmodule

module segment_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int VALUE_WIDTH = 8,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                 clk,
    input  logic                 reset,
    segment_scan_driver_if.slave bus
);
    localparam int SD   = NUM_DIGITS - 1;
    localparam int BW   = 4 * NUM_DIGITS;
    localparam int PADW = (VALUE_WIDTH > BW) ? VALUE_WIDTH : BW;
    localparam int CW   = (VALUE_WIDTH > 2) ? $clog2(VALUE_WIDTH) : 1;
    localparam int RW   = $clog2(REFRESH_DIV);
    localparam int IW   = $clog2(NUM_DIGITS);

    typedef enum logic [1:0] {ST_IDLE, ST_CONV, ST_COMMIT} state_t;

    state_t                 state_q, state_d;
    logic [VALUE_WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]          bcd_q, bcd_d;
    logic [CW-1:0]          bitcnt_q, bitcnt_d;
    logic                   sticky_q, sticky_d;
    logic                   negp_q, negp_d;

    logic [SD-1:0][3:0]     dig_q, dig_d;
    logic [SD-1:0]          fblank_q, fblank_d;
    logic                   neg_q, neg_d;

    logic [RW-1:0]          ref_q, ref_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [NUM_DIGITS-1:0]  den_q, den_d;
    logic [6:0]             seg_q, seg_d;

    logic [BW-1:0]          bcd_adj;
    logic [BW-1:0]          bcd_shift;
    logic                   bcd_carry;
    logic [PADW-1:0]        val_pad;
    logic                   hex_ovf;
    logic [SD-1:0][3:0]     hex_dig, dec_dig;

    logic                   commit_en;
    logic                   commit_ovf;
    logic                   commit_neg;
    logic [SD-1:0][3:0]     commit_dig;

    logic [SD-1:0]          nz;
    logic [6:0]             enc  [SD];
    logic [6:0]             disp [NUM_DIGITS];

    // Shift-add-3 datapath: adjust every nibble, then shift in the next value bit.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                        bcd_q[gi*4 +: 4] + 4'd3 : bcd_q[gi*4 +: 4];
        end
    endgenerate

    assign bcd_shift = {bcd_adj[BW-2:0], shift_q[VALUE_WIDTH-1]};
    assign bcd_carry = bcd_adj[BW-1];
    assign val_pad   = PADW'(bus.value);
    assign hex_ovf   = |val_pad[PADW-1:4*SD];

    generate
        for (genvar gi = 0; gi < SD; gi++) begin : g_src
            assign hex_dig[gi] = val_pad[4*gi +: 4];
            assign dec_dig[gi] = bcd_shift[4*gi +: 4];
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bcd_d      = bcd_q;
        bitcnt_d   = bitcnt_q;
        sticky_d   = sticky_q;
        negp_d     = negp_q;
        commit_en  = 1'b0;
        commit_ovf = 1'b0;
        commit_neg = 1'b0;
        commit_dig = hex_dig;
        case (state_q)
            ST_CONV: begin
                shift_d  = shift_q << 1;
                bcd_d    = bcd_shift;
                sticky_d = sticky_q | bcd_carry;
                bitcnt_d = bitcnt_q + 1'b1;
                if (bitcnt_q == CW'(VALUE_WIDTH - 1)) begin
                    state_d    = ST_COMMIT;
                    commit_en  = 1'b1;
                    commit_dig = dec_dig;
                    // Bits lost off the top also count as overflow, not just the guard digit.
                    commit_ovf = sticky_q | bcd_carry | (|bcd_shift[BW-1 -: 4]);
                    commit_neg = negp_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                if (bus.load) begin
                    if (bus.is_dec) begin
                        state_d  = ST_CONV;
                        shift_d  = bus.value;
                        bcd_d    = '0;
                        bitcnt_d = '0;
                        sticky_d = 1'b0;
                        negp_d   = bus.is_negative && (bus.value != '0);
                    end else begin
                        commit_en  = 1'b1;
                        commit_dig = hex_dig;
                        commit_ovf = hex_ovf;
                        commit_neg = bus.is_negative && (bus.value != '0);
                    end
                end
            end
        endcase
    end

    always_comb begin
        dig_d    = dig_q;
        fblank_d = fblank_q;
        neg_d    = neg_q;
        if (commit_en) begin
            if (commit_ovf) begin
                dig_d       = '0;
                dig_d[0]    = 4'hE;
                fblank_d    = '1;
                fblank_d[0] = 1'b0;
                neg_d       = 1'b0;
            end else begin
                dig_d    = commit_dig;
                fblank_d = '0;
                neg_d    = commit_neg;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < SD; gi++) begin : g_disp
            logic lz_blank;
            assign nz[gi] = |dig_q[gi];
            if (gi == 0) begin : g_lsd
                assign lz_blank = 1'b0;
            end else begin : g_upper
                assign lz_blank = bus.blank_zeros & ~(|nz[SD-1:gi]);
            end
            hex_display u_hex (
                .nibble_i (dig_q[gi]),
                .seg_o    (enc[gi])
            );
            assign disp[gi] = (fblank_q[gi] || lz_blank) ? 7'h7F : enc[gi];
        end
    endgenerate

    assign disp[NUM_DIGITS-1] = neg_q ? 7'h3F : 7'h7F;

    always_comb begin
        ref_d = ref_q + 1'b1;
        idx_d = idx_q;
        if (ref_q == RW'(REFRESH_DIV - 1)) begin
            ref_d = '0;
            idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        den_d = ~(NUM_DIGITS'(1) << idx_q);
        seg_d = disp[idx_q];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            bcd_q    <= '0;
            bitcnt_q <= '0;
            sticky_q <= 1'b0;
            negp_q   <= 1'b0;
            dig_q    <= '0;
            fblank_q <= '1;
            neg_q    <= 1'b0;
            ref_q    <= '0;
            idx_q    <= '0;
            den_q    <= '1;
            seg_q    <= 7'h7F;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bcd_q    <= bcd_d;
            bitcnt_q <= bitcnt_d;
            sticky_q <= sticky_d;
            negp_q   <= negp_d;
            dig_q    <= dig_d;
            fblank_q <= fblank_d;
            neg_q    <= neg_d;
            ref_q    <= ref_d;
            idx_q    <= idx_d;
            den_q    <= den_d;
            seg_q    <= seg_d;
        end
    end

    assign bus.busy     = (state_q == ST_CONV);
    assign bus.digit_en = den_q;
    assign bus.segments = seg_q;
endmodule

// File: tb/tb_segment_scan_driver.sv
// Directed bench for segment_scan_driver: a 4-digit/8-bit instance and a 3-digit/9-bit one.
module tb_segment_scan_driver;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    segment_scan_driver_if #(.NUM_DIGITS(4), .VALUE_WIDTH(8)) bus_a ();
    segment_scan_driver_if #(.NUM_DIGITS(3), .VALUE_WIDTH(9)) bus_b ();

    segment_scan_driver #(.NUM_DIGITS(4), .VALUE_WIDTH(8), .REFRESH_DIV(4)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    segment_scan_driver #(.NUM_DIGITS(3), .VALUE_WIDTH(9), .REFRESH_DIV(4)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("[TB] check %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [7:0] v, input logic dec, input logic neg);
        bus_a.value = v; bus_a.is_dec = dec; bus_a.is_negative = neg; bus_a.load = 1'b1;
        tick();
        bus_a.load = 1'b0;
    endtask

    task automatic load_b(input logic [8:0] v, input logic dec, input logic neg);
        bus_b.value = v; bus_b.is_dec = dec; bus_b.is_negative = neg; bus_b.load = 1'b1;
        tick();
        bus_b.load = 1'b0;
    endtask

    task automatic wait_idle_a();
        for (int n = 0; n < 40 && bus_a.busy; n++) tick();
        chk("idle_a_timeout", {31'd0, bus_a.busy}, 32'd0);
    endtask

    task automatic wait_idle_b();
        for (int n = 0; n < 40 && bus_b.busy; n++) tick();
        chk("idle_b_timeout", {31'd0, bus_b.busy}, 32'd0);
    endtask

    // Walk one full scan and record the segments seen with each digit enabled.
    task automatic cap_a(output logic [27:0] s, output logic bsy);
        logic [3:0] got;
        logic [3:0] oh;
        got = '0; bsy = 1'b0; s = '1;
        tick();
        for (int n = 0; n < 60 && got != 4'hF; n++) begin
            for (int k = 0; k < 4; k++) begin
                oh = 4'b1 << k;
                if (bus_a.digit_en == ~oh) begin
                    s[k*7 +: 7] = bus_a.segments;
                    got[k] = 1'b1;
                end
            end
            if (bus_a.busy) bsy = 1'b1;
            tick();
        end
        chk("cap_a_timeout", {28'd0, got}, 32'hF);
    endtask

    task automatic cap_b(output logic [20:0] s);
        logic [2:0] got;
        logic [2:0] oh;
        got = '0; s = '1;
        tick();
        for (int n = 0; n < 60 && got != 3'h7; n++) begin
            for (int k = 0; k < 3; k++) begin
                oh = 3'b1 << k;
                if (bus_b.digit_en == ~oh) begin
                    s[k*7 +: 7] = bus_b.segments;
                    got[k] = 1'b1;
                end
            end
            tick();
        end
        chk("cap_b_timeout", {29'd0, got}, 32'h7);
    endtask

    initial begin
        logic [27:0] sa;
        logic [20:0] sb;
        logic        bsy;
        int          n;
        logic [3:0]  scan_exp [5];
        scan_exp = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};

        bus_a.load = 0; bus_a.value = 0; bus_a.is_negative = 0; bus_a.is_dec = 0; bus_a.blank_zeros = 0;
        bus_b.load = 0; bus_b.value = 0; bus_b.is_negative = 0; bus_b.is_dec = 0; bus_b.blank_zeros = 0;
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_busy", {31'd0, bus_a.busy}, 32'd0);
        chk("rst_seg", {25'd0, bus_a.segments}, 32'h7F);
        chk("rst_den", {28'd0, bus_a.digit_en}, 32'hF);
        reset = 1'b0;
        chk("rel_den_hold", {28'd0, bus_a.digit_en}, 32'hF);
        tick();
        chk("rel_den_first", {28'd0, bus_a.digit_en}, 32'hE);
        chk("rst_seg_b", {25'd0, bus_b.segments}, 32'h7F);

        // Reset in the middle of a conversion aborts it and leaves the frame blank.
        load_a(8'd255, 1'b1, 1'b1);
        tick(); tick();
        chk("midconv_busy", {31'd0, bus_a.busy}, 32'd1);
        reset = 1'b1;
        repeat (3) tick();
        chk("midrst_busy", {31'd0, bus_a.busy}, 32'd0);
        chk("midrst_seg", {25'd0, bus_a.segments}, 32'h7F);
        chk("midrst_den", {28'd0, bus_a.digit_en}, 32'hF);
        reset = 1'b0;
        tick();
        chk("midrst_den_next", {28'd0, bus_a.digit_en}, 32'hE);
        cap_a(sa, bsy);
        chk("midrst_frame", {4'd0, sa}, {4'd0, 7'h7F, 7'h7F, 7'h7F, 7'h7F});

        // Hex 0x3C.
        bus_a.blank_zeros = 1'b1;
        load_a(8'h3C, 1'b0, 1'b0);
        chk("hex_busy", {31'd0, bus_a.busy}, 32'd0);
        cap_a(sa, bsy);
        chk("hex_frame_blank", {4'd0, sa}, {4'd0, 7'h7F, 7'h7F, 7'h30, 7'h46});
        chk("hex_busy_seen", {31'd0, bsy}, 32'd0);
        bus_a.blank_zeros = 1'b0;
        cap_a(sa, bsy);
        chk("hex_frame_zeros", {4'd0, sa}, {4'd0, 7'h7F, 7'h40, 7'h30, 7'h46});

        // Decimal -255: busy exactly VALUE_WIDTH cycles.
        load_a(8'd255, 1'b1, 1'b1);
        n = 0;
        while (bus_a.busy && n < 20) begin n++; tick(); end
        chk("dec_busy_cycles", n, 32'd8);
        cap_a(sa, bsy);
        chk("dec_m255", {4'd0, sa}, {4'd0, 7'h3F, 7'h24, 7'h12, 7'h12});

        // Leading-zero blanking and negative zero.
        bus_a.blank_zeros = 1'b1;
        load_a(8'd7, 1'b1, 1'b0);
        wait_idle_a();
        cap_a(sa, bsy);
        chk("dec_7_blank", {4'd0, sa}, {4'd0, 7'h7F, 7'h7F, 7'h7F, 7'h78});
        load_a(8'd0, 1'b1, 1'b1);
        wait_idle_a();
        cap_a(sa, bsy);
        chk("dec_negzero_blank", {4'd0, sa}, {4'd0, 7'h7F, 7'h7F, 7'h7F, 7'h40});
        bus_a.blank_zeros = 1'b0;
        cap_a(sa, bsy);
        chk("dec_negzero_zeros", {4'd0, sa}, {4'd0, 7'h7F, 7'h40, 7'h40, 7'h40});

        // A load while busy is dropped.
        bus_a.blank_zeros = 1'b1;
        load_a(8'd18, 1'b1, 1'b0);
        tick();
        load_a(8'd99, 1'b1, 1'b1);
        wait_idle_a();
        repeat (4) tick();
        chk("drop_idle", {31'd0, bus_a.busy}, 32'd0);
        cap_a(sa, bsy);
        chk("drop_frame", {4'd0, sa}, {4'd0, 7'h7F, 7'h7F, 7'h79, 7'h00});

        // Scan order and dwell with REFRESH_DIV=4.
        for (int i = 0; i < 20 && bus_a.digit_en == 4'hE; i++) tick();
        for (int i = 0; i < 20 && bus_a.digit_en != 4'hE; i++) tick();
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("scan_g%0d_c%0d", g, c), {28'd0, bus_a.digit_en}, {28'd0, scan_exp[g]});
                tick();
            end
        end

        // Three-digit instance: overflow in both radices and the largest fitting values.
        load_b(9'd100, 1'b1, 1'b0);
        wait_idle_b();
        cap_b(sb);
        chk("b_dec_ovf", {11'd0, sb}, {11'd0, 7'h7F, 7'h7F, 7'h06});
        load_b(9'h1FF, 1'b0, 1'b1);
        chk("b_hex_busy", {31'd0, bus_b.busy}, 32'd0);
        cap_b(sb);
        chk("b_hex_ovf", {11'd0, sb}, {11'd0, 7'h7F, 7'h7F, 7'h06});
        load_b(9'h0FF, 1'b0, 1'b1);
        cap_b(sb);
        chk("b_hex_ff_neg", {11'd0, sb}, {11'd0, 7'h3F, 7'h0E, 7'h0E});
        load_b(9'd99, 1'b1, 1'b1);
        wait_idle_b();
        cap_b(sb);
        chk("b_dec_m99", {11'd0, sb}, {11'd0, 7'h3F, 7'h10, 7'h10});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
